out_pass_delay_frame_config: RTL and testbench
==============================================

// Module: out_pass_delay_frame_config
// PURPOSE
//  Parametrised successor of the fixed 4-channel output pass/flop block.
//  Drives NUM_CH fabric output signals to the tile edge. Each channel is independently
//  configured from frame config bits into one of four modes:
//  - combinational pass
//  - programmable delay line
//  - rising-edge pulse
//  - retriggerable pulse stretcher
//  Sits between the switch matrix and EXTERNAL tile outputs.
// PARAMETERS
//  NUM_CH       4   number of independent channels
//  DEPTH_BITS   2   delay/stretch select width; MAX_DEPTH = 2**DEPTH_BITS (must be >=1)
//  CFG_W        4   config bits per channel = 2 + DEPTH_BITS (set manually)
//  NoConfigBits 16  NUM_CH*CFG_W (set manually, no arithmetic parser)
// PORTS
//  UserCLK     in   1             user clock; EXTERNAL, SHARED_PORT
//  UserRSTn    in   1             synchronous reset, active-low
//  I           in   NUM_CH        channel inputs from the switch matrix
//  O           out  NUM_CH        channel outputs; EXTERNAL
//  ConfigBits  in   NoConfigBits  frame config; channel k uses ConfigBits[k*CFG_W +: CFG_W]
// BEHAVIOUR
//  Per-channel config fields:
//  - MODE  = cfg[1:0]
//  - DELAY = cfg[CFG_W-1:2]
//  ConfigBits is static during normal use but may change at any time; it only selects outputs.
//  Per-channel state:
//  - shift register sr[0..MAX_DEPTH-1]
//  - stretch counter cnt (DEPTH_BITS+1 bits)
//  State runs every cycle regardless of MODE.
//  Reset (UserRSTn==0 at posedge UserCLK):
//  - all sr and cnt cleared to 0
//  - O = I for MODE 0; O = 0 for MODEs 1-3 (while held and after)
//  Every posedge when not in reset:
//  - sr[0] <= I[k]
//  - sr[j] <= sr[j-1]
//  MODE 0 (pass): O = I, combinational, zero latency. Identical to the unregistered path.
//  MODE 1 (delay): O = sr[DELAY]
//  - latency is DELAY+1 cycles
//  - DELAY=0 is the legacy single-flop path
//  MODE 2 (edge): O = sr[0] & ~sr[1]
//  - one-cycle pulse starting 1 cycle after a sampled 0->1 of I
//  - no pulse while I is held high
//  MODE 3 (stretch): at each posedge:
//  - if I==1 && sr[0]==0 (sampled rise): cnt <= DELAY+1
//  - else if cnt!=0: cnt <= cnt-1
//  - O = (cnt!=0)
//  - a rise sampled at edge t drives O high from t for exactly DELAY+1 cycles
//  - a new rise while cnt!=0 reloads cnt (retrigger), so the pulse extends
//  - if reload and decrement coincide, reload wins
//  - cnt never wraps: it saturates at 0
//  Boundary cases:
//  - I high at the first edge after reset counts as a rise (sr[0]==0 after reset)
//  - reset mid-pulse or mid-delay: O drops to 0 on that edge; in-flight data is discarded
//  - mode change: the output switches at once to the new mode's view of the live state;
//    no flush and no glitch suppression
//  Channels are fully independent; no cross-channel interaction.
// TESTING
//  T1: all MODE 0, toggle I=4'b1010->4'b0101 -> O follows in the same cycle, also during reset.
//  T2: ch0 MODE1 DELAY=0..3, single-cycle pulse on I[0] -> O[0] pulse delayed by 1/2/3/4 cycles.
//  T3: ch1 MODE2, I[1] high for 5 cycles -> O[1] high for exactly 1 cycle, 1 cycle after rise.
//  T4: ch2 MODE3 DELAY=2, 1-cycle I pulse -> O high 3 cycles.
//      Second rise 2 cycles later -> O stays high 3 cycles past the second rise.
//  T5: ch3 MODE1 DELAY=3 with data in flight, assert UserRSTn=0 one cycle
//      -> O=0 next cycle; old data never appears.
//  T6: NUM_CH=8, DEPTH_BITS=3, CFG_W=5, NoConfigBits=40 -> T2/T4 pass with DELAY=7
//      (8-cycle delay, 8-cycle stretch).

Source files
------------

// File: rtl/out_pass_delay_frame_config.sv
// Per-channel tile-edge output stage: pass, delay line, rising-edge pulse or
// retriggerable pulse stretcher, selected per channel by frame config bits.
module out_pass_delay_frame_config #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DEPTH_BITS   = 2,
    parameter int unsigned CFG_W        = 4,
    parameter int unsigned NoConfigBits = 16
) (
    input  logic                    UserCLK,
    input  logic                    UserRSTn,
    input  logic [NUM_CH-1:0]       I,
    output logic [NUM_CH-1:0]       O,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    localparam int unsigned MAX_DEPTH = 1 << DEPTH_BITS;
    localparam int unsigned CNT_W     = DEPTH_BITS + 1;

    localparam logic [1:0] MODE_PASS    = 2'd0;
    localparam logic [1:0] MODE_DELAY   = 2'd1;
    localparam logic [1:0] MODE_EDGE    = 2'd2;
    localparam logic [1:0] MODE_STRETCH = 2'd3;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [MAX_DEPTH-1:0]  sr;
        logic [CNT_W-1:0]      cnt;
        logic [1:0]            mode;
        logic [DEPTH_BITS-1:0] delay;
        logic                  out_bit;

        assign mode  = ConfigBits[k*CFG_W +: 2];
        assign delay = ConfigBits[k*CFG_W+2 +: DEPTH_BITS];

        // History and stretch counter run every cycle so a mode change sees live state.
        always_ff @(posedge UserCLK) begin
            if (!UserRSTn) begin
                sr  <= '0;
                cnt <= '0;
            end else begin
                sr <= {sr[MAX_DEPTH-2:0], I[k]};
                if (I[k] && !sr[0]) begin
                    cnt <= CNT_W'(delay) + CNT_W'(1);
                end else if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end

        // Output view; config only selects, it never touches state.
        always_comb begin
            out_bit = 1'b0;
            case (mode)
                MODE_PASS:    out_bit = I[k];
                MODE_DELAY:   out_bit = sr[delay];
                MODE_EDGE:    out_bit = sr[0] & ~sr[1];
                MODE_STRETCH: out_bit = (cnt != '0);
                default:      out_bit = 1'b0;
            endcase
        end

        assign O[k] = out_bit;
    end

endmodule

// File: tb/tb_out_pass_delay_frame_config.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_out_pass_delay_frame_config;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn_a, rstn_b;
    logic [3:0]  i_a, o_a;
    logic [15:0] cfg_a;
    logic [7:0]  i_b, o_b;
    logic [39:0] cfg_b;

    out_pass_delay_frame_config dut_a (
        .UserCLK    (clk),
        .UserRSTn   (rstn_a),
        .I          (i_a),
        .O          (o_a),
        .ConfigBits (cfg_a)
    );

    out_pass_delay_frame_config #(
        .NUM_CH       (8),
        .DEPTH_BITS   (3),
        .CFG_W        (5),
        .NoConfigBits (40)
    ) dut_b (
        .UserCLK    (clk),
        .UserRSTn   (rstn_b),
        .I          (i_b),
        .O          (o_b),
        .ConfigBits (cfg_b)
    );

    typedef struct {
        logic [7:0] exp;
        logic [7:0] mask;
        int         tst;
        int         idx;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input logic [7:0] act, input exp_t e, input string name);
        n_cmp++;
        if ((act & e.mask) !== (e.exp & e.mask)) begin
            n_bad++;
            $display("FAIL %s T%0d[%0d]: O=%b expected %b (mask %b)",
                     name, e.tst, e.idx, act, e.exp, e.mask);
        end
    endtask

    always @(negedge clk) begin
        if (q_a.size() != 0) begin
            ea = q_a.pop_front();
            check(8'(o_a), ea, "dut4");
        end
        if (q_b.size() != 0) begin
            eb = q_b.pop_front();
            check(o_b, eb, "dut8");
        end
    end

    task automatic cyc_a(input logic rst_n, input logic [3:0] i, input logic [15:0] cfg,
                         input logic [3:0] exp, input logic [3:0] mask,
                         input int tst, input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        rstn_a = rst_n;
        i_a    = i;
        cfg_a  = cfg;
        e.exp  = 8'(exp);
        e.mask = 8'(mask);
        e.tst  = tst;
        e.idx  = idx;
        q_a.push_back(e);
    endtask

    task automatic idle_a(input logic [15:0] cfg, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            rstn_a = 1'b1;
            i_a    = 4'b0000;
            cfg_a  = cfg;
        end
    endtask

    task automatic cyc_b(input logic rst_n, input logic [7:0] i, input logic [39:0] cfg,
                         input logic [7:0] exp, input logic [7:0] mask,
                         input int tst, input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        rstn_b = rst_n;
        i_b    = i;
        cfg_b  = cfg;
        e.exp  = exp;
        e.mask = mask;
        e.tst  = tst;
        e.idx  = idx;
        q_b.push_back(e);
    endtask

    initial begin
        logic [15:0] cfg;
        logic [39:0] cfg8;
        logic [1:0]  dl;
        logic        bit0, bit1;

        rstn_a = 1'b0;
        i_a    = 4'b1010;
        cfg_a  = '0;
        rstn_b = 1'b0;
        i_b    = '0;
        cfg_b  = '0;

        // T1 pass mode through and out of reset; delay mode reads 0 while held in reset
        cyc_a(1'b0, 4'b1010, 16'h0000, 4'b1010, 4'hF, 1, 0);
        cyc_a(1'b0, 4'b0101, 16'h0000, 4'b0101, 4'hF, 1, 1);
        cyc_a(1'b0, 4'b1111, 16'h1111, 4'b0000, 4'hF, 1, 2);
        cyc_a(1'b0, 4'b1111, 16'h1111, 4'b0000, 4'hF, 1, 3);
        cyc_a(1'b1, 4'b1010, 16'h0000, 4'b1010, 4'hF, 1, 4);
        cyc_a(1'b1, 4'b0101, 16'h0000, 4'b0101, 4'hF, 1, 5);
        // switching to delay=0 shows the live sr[0] (last sampled I) at once
        cyc_a(1'b1, 4'b0000, 16'h1111, 4'b0101, 4'hF, 1, 6);
        idle_a(16'h1111, 5);

        // T2 ch0 delay line, pulse appears DELAY+1 cycles later
        for (int d = 0; d < 4; d++) begin
            dl  = 2'(d);
            cfg = {12'h000, dl, 2'b01};
            for (int j = 0; j < 8; j++) begin
                cyc_a(1'b1, (j == 0) ? 4'b0001 : 4'b0000, cfg,
                      (j == d + 1) ? 4'b0001 : 4'b0000, 4'b0001, 2, d * 8 + j);
            end
        end

        // T3 ch1 edge mode, I held high 5 cycles gives one pulse
        for (int j = 0; j < 8; j++) begin
            cyc_a(1'b1, (j < 5) ? 4'b0010 : 4'b0000, 16'h0020,
                  (j == 1) ? 4'b0010 : 4'b0000, 4'b0010, 3, j);
        end

        // T4 ch2 stretch DELAY=2, rises at j=0 and j=2 (retrigger)
        for (int j = 0; j < 9; j++) begin
            cyc_a(1'b1, (j == 0 || j == 2) ? 4'b0100 : 4'b0000, 16'h0B00,
                  (j >= 1 && j <= 5) ? 4'b0100 : 4'b0000, 4'b0100, 4, j);
        end
        // I held high across reset: first edge after reset is a rise, no re-fire while high
        for (int j = 0; j < 8; j++) begin
            cyc_a((j != 0), (j <= 6) ? 4'b0100 : 4'b0000, 16'h0B00,
                  (j >= 2 && j <= 4) ? 4'b0100 : 4'b0000, 4'b0100, 4, 100 + j);
        end

        // T5 ch3 delay 3, reset with data in flight discards it
        for (int j = 0; j < 10; j++) begin
            cyc_a((j != 3), (j == 0 || j == 1 || j == 4) ? 4'b1000 : 4'b0000, 16'hD000,
                  (j == 8) ? 4'b1000 : 4'b0000, 4'b1000, 5, j);
        end

        // T6 wide instance: ch0 delay 7, ch1 stretch 7
        cfg8 = {30'd0, 5'b11111, 5'b11101};
        cyc_b(1'b1, 8'h00, cfg8, 8'h00, 8'h03, 6, 0);
        cyc_b(1'b1, 8'h00, cfg8, 8'h00, 8'h03, 6, 1);
        for (int j = 0; j < 11; j++) begin
            bit0 = (j == 8);
            bit1 = (j >= 1 && j <= 8);
            cyc_b(1'b1, (j == 0) ? 8'h03 : 8'h00, cfg8,
                  {6'd0, bit1, bit0}, 8'h03, 6, 10 + j);
        end

        @(posedge clk);
        @(posedge clk);
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d/%0d expected entries never compared", q_a.size(), q_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
